// File: rtl/alu_fp_pkg.sv
// Shared FP ALU constants, divider state type and iteration count.
// Optional feature macro: MANT_DIV_ROUND_EN (guard bit plus round-to-nearest).
package alu_fp_pkg;

   localparam int unsigned MANT_W         = 24;
   localparam int unsigned FRAC_W         = 23;
   localparam int unsigned REM_W          = MANT_W + 2;
   localparam int unsigned OTHER_W        = 2;
   localparam int unsigned OTHER_ZERO_BIT = 1;
   localparam int unsigned OTHER_DEC_BIT  = 0;
   localparam int unsigned DIV_ITER_DEF   = 25;
`ifdef MANT_DIV_ROUND_EN
   localparam int unsigned DIV_ITER       = DIV_ITER_DEF + 1;
`else
   localparam int unsigned DIV_ITER       = DIV_ITER_DEF;
`endif
   localparam int unsigned CNT_W          = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      NORM = 2'd2
   } div_state_e;

endpackage

// File: rtl/mant_div_unit_step.sv
// One restoring-division iteration: compare, conditional subtract, shift left.
module mant_div_step
   import alu_fp_pkg::*;
(
   input  logic [REM_W-1:0]  rem,
   input  logic [MANT_W-1:0] b,
   output logic [REM_W-1:0]  rem_next,
   output logic              qbit
);

   logic [REM_W-1:0] b_ext;
   logic [REM_W-1:0] diff;

   // rem stays below 2*b, so the shifted difference always fits REM_W bits
   always_comb begin
      b_ext    = {2'b00, b};
      qbit     = (rem >= b_ext);
      diff     = rem - b_ext;
      rem_next = qbit ? {diff[REM_W-2:0], 1'b0} : {rem[REM_W-2:0], 1'b0};
   end

endmodule

// File: rtl/mant_div_unit.sv
// Sequential mantissa divider: one quotient bit per cycle, normalized fraction out.
// Optional feature macro: MANT_DIV_ROUND_EN (extra guard bit, round to nearest).
module mant_div_unit
   import alu_fp_pkg::*;
(
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [MANT_W-1:0]   data1_in,
   input  logic [MANT_W-1:0]   data2_in,
   input  logic                trig,
   output logic [FRAC_W-1:0]   result_out,
   output logic [OTHER_W-1:0]  other_out,
   output logic                result_vld,
   output logic                busy
);

   div_state_e           state;
   logic [MANT_W-1:0]    b_r;
   logic [REM_W-1:0]     rem;
   logic [DIV_ITER-1:0]  q;
   logic [CNT_W-1:0]     cnt;
   logic                 zero_r;

   logic [REM_W-1:0]     rem_next;
   logic                 qbit;
   logic                 q_ge_one;
   logic [FRAC_W-1:0]    frac_sel;
   logic [FRAC_W-1:0]    frac_c;
   logic [OTHER_W-1:0]   other_c;

   mant_div_step u_step (
      .rem      (rem),
      .b        (b_r),
      .rem_next (rem_next),
      .qbit     (qbit)
   );

   // Pick the 23 fraction bits just below the leading one of the quotient
   always_comb begin
      q_ge_one = q[DIV_ITER-1];
      frac_sel = q_ge_one ? q[DIV_ITER-2 -: FRAC_W] : q[DIV_ITER-3 -: FRAC_W];
   end

`ifdef MANT_DIV_ROUND_EN
   localparam int unsigned SUM_W = FRAC_W + 1;
   logic             guard;
   logic [SUM_W-1:0] rnd_sum;
   logic             sat_fire;

   // Round half away from zero; a carry out cannot occur, saturate regardless
   always_comb begin
      guard    = q_ge_one ? q[1] : q[0];
      rnd_sum  = {1'b0, frac_sel} + SUM_W'(guard);
      sat_fire = rnd_sum[SUM_W-1] && (state == NORM) && !zero_r;
      frac_c   = rnd_sum[SUM_W-1] ? {FRAC_W{1'b1}} : rnd_sum[FRAC_W-1:0];
   end
`else
   // Truncation: remainder bits below the fraction are dropped
   always_comb begin
      frac_c = frac_sel;
   end
`endif

   // Flag word: zero result, or quotient below one (exponent decrement)
   always_comb begin
      other_c                = '0;
      other_c[OTHER_ZERO_BIT] = zero_r;
      other_c[OTHER_DEC_BIT]  = !zero_r && !q_ge_one;
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         b_r        <= '0;
         rem        <= '0;
         q          <= '0;
         cnt        <= '0;
         zero_r     <= 1'b0;
         result_out <= '0;
         other_out  <= '0;
         result_vld <= 1'b0;
         busy       <= 1'b0;
      end else begin
         result_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (trig) begin
                  b_r  <= data2_in;
                  busy <= 1'b1;
                  if (!data1_in[MANT_W-1] || !data2_in[MANT_W-1]) begin
                     zero_r <= 1'b1;
                     state  <= NORM;
                  end else begin
                     zero_r <= 1'b0;
                     rem    <= {2'b00, data1_in};
                     q      <= '0;
                     cnt    <= '0;
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               q   <= {q[DIV_ITER-2:0], qbit};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DIV_ITER - 1)) begin
                  state <= NORM;
               end
            end
            NORM: begin
               result_out <= zero_r ? '0 : frac_c;
               other_out  <= other_c;
               result_vld <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mant_div_unit.md
# mant_div_unit

Shared mantissa divider serving the IEEE-754 single-precision divide front-end in the ALU. It accepts two 24-bit mantissas (hidden bit included) on a one-cycle trigger and runs a sequential restoring division, one quotient bit per cycle. It returns a normalized 23-bit fraction, an exponent-decrement flag and a zero flag with a one-cycle valid pulse. The divide front-end owns sign, exponent and special-value handling; this block only divides mantissas.

## Interface
- No parameters; widths are fixed by package constants.
- sys_clk  in  1  clock; reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- sys_rst_n  in  1  asynchronous active-low reset.
- data1_in  in  24  dividend mantissa {hidden, frac}; sampled only on accepted trig.
- data2_in  in  24  divisor mantissa; sampled only on accepted trig.
- trig  in  1  single-cycle start request.
- result_out  out  23  normalized quotient fraction; held until next completion.
- other_out  out  2  [1] zero result, [0] quotient < 1 (caller decrements exponent); held.
- result_vld  out  1  one-cycle completion pulse.
- busy  out  1  high while state != IDLE.

## Operation
- States: IDLE, CALC, NORM.
- IDLE: trig=1 latches a=data1_in and b=data2_in.
  - If a[23]==0 or b[23]==0, the operand counts as zero. Go directly to NORM with the zero flag set.
  - Otherwise load rem=a (26 bits), q=0, cnt=0, and go to CALC.
- trig outside IDLE is ignored; no queuing.
- CALC, one step per cycle:
  - If rem >= {2'b0,b}: q = {q,1} and rem = (rem-b)<<1.
  - Else: q = {q,0} and rem = rem<<1.
  - cnt increments each step. Exit to NORM after N steps.
  - N=25 by default. The first bit has weight 2^0 and the last bit has weight 2^-24.
- Quotient range is (0.5, 2); the maximum is exactly 2-2^-23 (a=0xFFFFFF, b=0x800000).
- NORM, one cycle, registers the outputs:
  - If q[N-1]==1: result_out = q[N-2:N-24], other_out = 2'b00.
  - Else: result_out = q[N-3:N-25], other_out = 2'b01.
  - Zero path: result_out = 0, other_out = 2'b10.
  - result_vld <= 1. Next state is IDLE.
- Default rounding: truncation. The remainder is discarded.
- Reset values:
  - result_out = 0, other_out = 0, result_vld = 0, busy = 0.
  - State = IDLE; internal rem, q and cnt = 0.

## Timing
- trig sampled at edge T.
- CALC occupies cycles T+1..T+N.
- NORM occupies cycle T+N+1.
- result_vld is high during cycle T+N+2 only: T+27 by default, T+28 with rounding.
- Zero path: NORM at T+1, result_vld at T+2.
- result_out and other_out become valid in the same cycle as result_vld and are stable until the next NORM.
- The result_vld cycle is in IDLE, so a trig in that cycle is accepted (back-to-back issue).
- busy rises the cycle after an accepted trig and falls in the result_vld cycle.
- Asynchronous reset mid-CALC or mid-NORM: return to IDLE immediately with all outputs cleared. No result_vld is produced for the aborted operation.

## Configuration
- MANT_DIV_ROUND_EN defined:
  - N=26; the extra bit is a guard bit.
  - Round to nearest, ties away from zero: fraction += guard.
  - In the q>=1 case the guard is q[1]; in the q<1 case the guard is q[0].
  - Rounding carry out of 23 bits is arithmetically impossible given the quotient bounds. The implementation saturates to 0x7FFFFF defensively, and the bench asserts the saturation never fires.
- MANT_DIV_ROUND_EN undefined: N=25, truncation, no guard logic.

## Structure
- Shared package alu_fp_pkg holds:
  - MANT_W=24, FRAC_W=23.
  - OTHER_ZERO_BIT=1, OTHER_DEC_BIT=0.
  - The state enum (IDLE/CALC/NORM).
  - The default iteration count.
- Sub-module mant_div_step: combinational compare/subtract/shift of one iteration (rem, b -> rem_next, qbit). It is instantiated once.

## Test plan
- a=0x800000, b=0x800000, trig at T -> result_vld at T+27, result_out=0x000000, other_out=2'b00.
- a=0xC00000, b=0x800000 -> result_out=0x400000, other_out=2'b00.
- a=0x800000, b=0xC00000 -> result_out=0x2AAAAA, other_out=2'b01. With MANT_DIV_ROUND_EN: 0x2AAAAB, result_vld at T+28.
- a=0xFFFFFF, b=0x800000 -> result_out=0x7FFFFF, other_out=2'b00. Back-to-back trig in the result_vld cycle is accepted and completes 27 cycles later.
- a=0, b=0x800000 (and separately a=0x800000, b=0) -> result_vld at T+2, result_out=0, other_out=2'b10.
- trig pulses during CALC are ignored (exactly one result_vld per accepted trig).
- sys_rst_n low at T+10 -> all outputs 0, no result_vld. A new trig after release completes normally.
